// File: rtl/gate_pipe.sv
// gate_pipe: two-stage pipelined bitwise AND/OR/NAND/NOR unit with a completed-transfer counter.
// Latency: a result appears on out_* one edge after its operands are captured in stage 1 (two registers deep).
// Backpressure: whole-pipeline stall; in_ready = !out_valid || out_ready. Optional macro GATE_PIPE_PARITY_EN adds out_parity.
module gate_pipe #(
    parameter int         WIDTH = 8,
    parameter logic [2:0] MODE  = 3'd0,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef GATE_PIPE_PARITY_EN
    output logic             out_parity,
`endif
    output logic [CNT_W-1:0] done_cnt
);

    // Fixed modes 5..7 fall back to NOR, matching the generate default branch.
    localparam bit         RUNTIME  = (MODE == 3'd4);
    localparam logic [1:0] FIXED_OP = (MODE < 3'd4) ? MODE[1:0] : 2'b11;
    localparam logic [1:0] RST_OP   = RUNTIME ? 2'b00 : FIXED_OP;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [WIDTH-1:0] op_res;
    logic             advance;

    // The op selector only matters in runtime mode; fold it into a sink elsewhere.
    logic unused_op;
    assign unused_op = ^{in_op, s1_op_q};

    // Exactly one operator is elaborated for the chosen MODE.
    generate
        case (MODE)
            3'd0: begin : g_and
                assign op_res = s1_a_q & s1_b_q;
            end
            3'd1: begin : g_or
                assign op_res = s1_a_q | s1_b_q;
            end
            3'd2: begin : g_nand
                assign op_res = ~(s1_a_q & s1_b_q);
            end
            3'd4: begin : g_runtime
                always_comb begin
                    case (s1_op_q)
                        2'b00:   op_res = s1_a_q & s1_b_q;
                        2'b01:   op_res = s1_a_q | s1_b_q;
                        2'b10:   op_res = ~(s1_a_q & s1_b_q);
                        default: op_res = ~(s1_a_q | s1_b_q);
                    endcase
                end
            end
            default: begin : g_nor
                assign op_res = ~(s1_a_q | s1_b_q);
            end
        endcase
    endgenerate

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done_cnt  = done_cnt_q;

    // Next-state: both stages shift together on advance, otherwise everything holds.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_cnt_d  = done_cnt_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            out_data_d  = op_res;
            s1_valid_d  = in_valid;
            s1_a_d      = in_a;
            s1_b_d      = in_b;
            s1_op_d     = RUNTIME ? in_op : FIXED_OP;
        end
        if (out_valid_q && out_ready) begin
            done_cnt_d = done_cnt_q + CNT_W'(1);
        end
    end

    // Pipeline and counter registers with synchronous reset that discards in-flight data.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= RST_OP;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

`ifdef GATE_PIPE_PARITY_EN
    logic out_parity_q, out_parity_d;

    // Parity of the stage-2 result, loaded alongside out_data so it stays aligned on stall.
    always_comb begin
        out_parity_d = advance ? ^op_res : out_parity_q;
    end

    // Parity register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_parity_q <= 1'b0;
        end else begin
            out_parity_q <= out_parity_d;
        end
    end

    assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_gate_pipe.sv
// tb_gate_pipe: six gate_pipe instances (modes 0,1,2,3,4,6; CNT_W=4) driven by shared stimulus.
// Each cycle every instance is compared with a cycle-level reference model of the two-stage pipe.
// Directed sequences cover the listed scenarios, followed by randomized traffic with random stalls/resets.
module tb_gate_pipe;

    localparam int N = 6;
    localparam logic [2:0] MODES [N] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic [7:0] in_a, in_b;
    logic [1:0] in_op;
    logic out_ready;

    logic [N-1:0]      ir, ov, par;
    logic [N-1:0][7:0] od;
    logic [N-1:0][3:0] dc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        gate_pipe #(.WIDTH(8), .MODE(MODES[g]), .CNT_W(4)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_a      (in_a),
            .in_b      (in_b),
            .in_op     (in_op),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_data  (od[g]),
`ifdef GATE_PIPE_PARITY_EN
            .out_parity(par[g]),
`endif
            .done_cnt  (dc[g])
        );
`ifndef GATE_PIPE_PARITY_EN
        assign par[g] = 1'b0;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: what the specification says each mode computes.
    function automatic logic [7:0] gate(input logic [2:0] mode, input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
        int sel;
        sel = (mode == 3'd4) ? int'(op) : ((mode < 3'd4) ? int'(mode) : 3);
        case (sel)
            0:       return a & b;
            1:       return a | b;
            2:       return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    // Model state: stage-1 operands, stage-2 valid and per-instance result, counter.
    logic       m1v;
    logic [7:0] m1a, m1b;
    logic [1:0] m1op;
    logic       m2v;
    logic [7:0] m2d [N];
    int         mcnt;

    logic       snap_ir, snap_ov;
    logic [7:0] snap_od;

    task automatic model_reset();
        m1v = 0; m1a = 0; m1b = 0; m1op = 0; m2v = 0; mcnt = 0;
        for (int g = 0; g < N; g++) m2d[g] = 8'h00;
    endtask

    task automatic model_step();
        logic adv;
        if (reset) begin
            model_reset();
        end else begin
            adv = !m2v || out_ready;
            if (m2v && out_ready) mcnt = (mcnt + 1) % 16;
            if (adv) begin
                m2v = m1v;
                for (int g = 0; g < N; g++) m2d[g] = gate(MODES[g], m1a, m1b, m1op);
                m1v = in_valid; m1a = in_a; m1b = in_b; m1op = in_op;
            end
        end
    endtask

    task automatic check_model();
        for (int g = 0; g < N; g++) begin
            chk($sformatf("in_ready[%0d]", g), 32'(ir[g]), 32'(!m2v || out_ready));
            chk($sformatf("out_valid[%0d]", g), 32'(ov[g]), 32'(m2v));
            chk($sformatf("out_data[%0d]", g), 32'(od[g]), 32'(m2d[g]));
            chk($sformatf("done_cnt[%0d]", g), 32'(dc[g]), 32'(mcnt));
`ifdef GATE_PIPE_PARITY_EN
            chk($sformatf("parity[%0d]", g), 32'(par[g]), 32'(^m2d[g]));
`endif
        end
    endtask

    // One cycle: drive inputs after the falling edge, check, then advance the model on the rising edge.
    task automatic tick(input logic rst, input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic ordy);
        @(negedge clk);
        reset = rst; in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = ordy;
        #1;
        check_model();
        snap_ir = ir[1]; snap_ov = ov[1]; snap_od = od[1];
        @(posedge clk);
        model_step();
    endtask

    logic [7:0] rt_exp [4];
    logic [7:0] bp_a [4];
    logic [7:0] bp_b [4];
    logic [7:0] bp_got [$];
    logic [7:0] held;
    int         k;

    initial begin
        reset = 1; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // AND: F0 & 3C.
        tick(0, 1, 8'hF0, 8'h3C, 2'b00, 1);
        tick(0, 0, 8'h00, 8'h00, 2'b00, 1);
        #1;
        chk("and_valid", 32'(ov[0]), 1);
        chk("and_data", 32'(od[0]), 32'h30);
        tick(0, 0, 8'h00, 8'h00, 2'b00, 1);
        #1;
        chk("and_cnt", 32'(dc[0]), 1);

        // Runtime mode: four ops back-to-back on AA/0F.
        rt_exp = '{8'h0A, 8'hAF, 8'hF5, 8'h50};
        for (int i = 0; i < 6; i++) begin
            tick(0, i < 4, 8'hAA, 8'h0F, 2'(i), 1);
            #1;
            if (i >= 1 && i <= 4) chk($sformatf("rt_op%0d", i - 1), 32'(od[4]), 32'(rt_exp[i - 1]));
        end

        // Backpressure on the OR instance: 4 items, consumer stalls after the first result.
        tick(1, 0, 8'h00, 8'h00, 2'b00, 1);
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = 8'(i * 17 + 1);
            bp_b[i] = 8'h80 >> i;
        end
        k = 0;
        held = 8'h00;
        for (int c = 0; c < 14; c++) begin
            logic ordy;
            ordy = !(c >= 2 && c <= 5);
            tick(0, k < 4, (k < 4) ? bp_a[k] : 8'h00, (k < 4) ? bp_b[k] : 8'h00, 2'b00, ordy);
            if (c == 2) held = snap_od;
            if (c >= 2 && c <= 5) begin
                chk("bp_stall_ready", 32'(snap_ir), 0);
                chk("bp_hold_data", 32'(snap_od), 32'(held));
            end
            if (snap_ov && ordy) bp_got.push_back(snap_od);
            if (snap_ir && k < 4) k++;
        end
        chk("bp_count", 32'(bp_got.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < bp_got.size()) chk($sformatf("bp_item%0d", i), 32'(bp_got[i]), 32'(bp_a[i] | bp_b[i]));

        // Reset with both stages valid, then a fresh transaction.
        tick(0, 1, 8'h12, 8'h34, 2'b01, 1);
        tick(0, 1, 8'h56, 8'h78, 2'b01, 0);
        tick(1, 0, 8'h00, 8'h00, 2'b00, 0);
        #1;
        chk("rst_valid", 32'(ov[4]), 0);
        chk("rst_data", 32'(od[4]), 0);
        chk("rst_cnt", 32'(dc[4]), 0);
        tick(0, 1, 8'hAA, 8'h0F, 2'b01, 1);
        tick(0, 0, 8'h00, 8'h00, 2'b00, 1);
        #1;
        chk("post_rst_valid", 32'(ov[4]), 1);
        chk("post_rst_data", 32'(od[4]), 32'hAF);

        // Counter wrap: 17 transfers on a 4-bit counter.
        tick(1, 0, 8'h00, 8'h00, 2'b00, 1);
        for (int i = 0; i < 17; i++) tick(0, 1, 8'(i), 8'(~i), 2'(i), 1);
        tick(0, 0, 8'h00, 8'h00, 2'b00, 1);
        tick(0, 0, 8'h00, 8'h00, 2'b00, 1);
        #1;
        chk("cnt_wrap", 32'(dc[4]), 1);

        // NOR of 00/01, with parity when present.
        tick(0, 1, 8'h00, 8'h01, 2'b11, 1);
        tick(0, 0, 8'h00, 8'h00, 2'b00, 1);
        #1;
        chk("nor_data", 32'(od[3]), 32'hFE);
        chk("nor_default_data", 32'(od[5]), 32'hFE);
`ifdef GATE_PIPE_PARITY_EN
        chk("nor_parity", 32'(par[3]), 1);
`endif

        // Randomized traffic with random stalls and occasional resets.
        for (int i = 0; i < 500; i++) begin
            tick($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                 2'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
